// File: rtl/riscv_pkg.sv
// Shared types and constants for the ID/EX issue stage and its decoder.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOP = 3'b111
  } alu_op_e;

  // Zero encodings are the bubble selections: src1=0, src2=imm (which is 0 in a bubble).
  typedef enum logic [1:0] {
    SRC1_ZERO = 2'd0,
    SRC1_RS1  = 2'd1,
    SRC1_PC   = 2'd2
  } src1_sel_e;

  typedef enum logic {
    SRC2_IMM = 1'b0,
    SRC2_RS2 = 1'b1
  } src2_sel_e;

  typedef struct packed {
    logic      valid;
    logic      regwrite;
    logic      memread;
    logic      memwrite;
    logic      use_rs1;
    logic      use_rs2;
    src1_sel_e src1_sel;
    src2_sel_e src2_sel;
    alu_op_e   alu;
  } dec_t;

  typedef struct packed {
    dec_t              dec;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } idex_t;

  // Operand bypass: EX/MEM wins over MEM/WB; x0 and unused sources keep the registered value.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   reg_data,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [XLEN-1:0]   mem_res,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_res
  );
    if (use_rs && (rs != '0)) begin
      if (mem_we && (mem_rd == rs)) return mem_res;
      if (wb_we && (wb_rd == rs))   return wb_res;
    end
    return reg_data;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bus between decode/forwarding sources and the ID/EX issue stage.
interface alu_issue_stage_if;
  import riscv_pkg::*;

  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [2:0]        id_funct3;
  logic              id_funct7_5;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic              flush;
  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_result;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_result;

  logic              id_stall;
  logic [XLEN-1:0]   alusrc1, alusrc2;
  logic [2:0]        alu_control;
  logic              ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7_5, id_pc, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, flush, mem_regwrite, mem_rd, mem_result,
           wb_regwrite, wb_rd, wb_result,
    input  id_stall, alusrc1, alusrc2, alu_control, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_rd, ex_store_data, ex_pc
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7_5, id_pc, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, flush, mem_regwrite, mem_rd, mem_result,
           wb_regwrite, wb_rd, wb_result,
    output id_stall, alusrc1, alusrc2, alu_control, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_rd, ex_store_data, ex_pc
  );
endinterface

// File: rtl/alu_issue_stage_alu_op_decode.sv
// Combinational decode of opcode/funct fields into ALU op, control bits and operand selects.
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic       valid_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output dec_t       dec_o
);

  alu_op_e arith_op;

  // ALU op for register/immediate arithmetic; SUB only for R-type with bit 30 set
  always_comb begin
    arith_op = ALU_NOP;
    case (funct3_i)
      3'b000:  arith_op = ((opcode_i == OP_RTYPE) && funct7_5_i) ? ALU_SUB : ALU_ADD;
      3'b100:  arith_op = ALU_XOR;
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_op = ALU_NOP;
    endcase
  end

  // Opcode decode; unknown opcodes and invalid slots decode to a bubble
  always_comb begin
    dec_o = '0;
    if (valid_i) begin
      case (opcode_i)
        OP_RTYPE: begin
          dec_o.valid = 1'b1; dec_o.regwrite = 1'b1;
          dec_o.use_rs1 = 1'b1; dec_o.use_rs2 = 1'b1;
          dec_o.src1_sel = SRC1_RS1; dec_o.src2_sel = SRC2_RS2; dec_o.alu = arith_op;
        end
        OP_IALU: begin
          dec_o.valid = 1'b1; dec_o.regwrite = 1'b1; dec_o.use_rs1 = 1'b1;
          dec_o.src1_sel = SRC1_RS1; dec_o.src2_sel = SRC2_IMM; dec_o.alu = arith_op;
        end
        OP_LOAD: begin
          dec_o.valid = 1'b1; dec_o.regwrite = 1'b1; dec_o.memread = 1'b1; dec_o.use_rs1 = 1'b1;
          dec_o.src1_sel = SRC1_RS1; dec_o.src2_sel = SRC2_IMM; dec_o.alu = ALU_ADD;
        end
        OP_STORE: begin
          dec_o.valid = 1'b1; dec_o.memwrite = 1'b1;
          dec_o.use_rs1 = 1'b1; dec_o.use_rs2 = 1'b1;
          dec_o.src1_sel = SRC1_RS1; dec_o.src2_sel = SRC2_IMM; dec_o.alu = ALU_ADD;
        end
        OP_BRANCH: begin
          dec_o.valid = 1'b1; dec_o.use_rs1 = 1'b1; dec_o.use_rs2 = 1'b1;
          dec_o.src1_sel = SRC1_RS1; dec_o.src2_sel = SRC2_RS2; dec_o.alu = ALU_SUB;
        end
        OP_LUI: begin
          dec_o.valid = 1'b1; dec_o.regwrite = 1'b1;
          dec_o.src1_sel = SRC1_ZERO; dec_o.src2_sel = SRC2_IMM; dec_o.alu = ALU_ADD;
        end
        OP_AUIPC: begin
          dec_o.valid = 1'b1; dec_o.regwrite = 1'b1;
          dec_o.src1_sel = SRC1_PC; dec_o.src2_sel = SRC2_IMM; dec_o.alu = ALU_ADD;
        end
        default: dec_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: registers decoded fields, forwards operands, detects load-use stalls.
module alu_issue_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  bus
);

  dec_t            id_dec;
  idex_t           idex_d, idex_q;
  logic            load_use;
  logic            stall;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] src1, src2;

  alu_op_decode u_decode (
    .valid_i    (bus.id_valid),
    .opcode_i   (bus.id_opcode),
    .funct3_i   (bus.id_funct3),
    .funct7_5_i (bus.id_funct7_5),
    .dec_o      (id_dec)
  );

  // Load in EX whose destination feeds a source the ID instruction actually reads
  always_comb begin
    load_use = idex_q.dec.valid && idex_q.dec.memread && (idex_q.rd != '0) &&
               ((id_dec.use_rs1 && (idex_q.rd == bus.id_rs1)) ||
                (id_dec.use_rs2 && (idex_q.rd == bus.id_rs2)));
    stall    = load_use && bus.id_valid && !bus.flush;
  end

  // Next ID/EX contents: flush or stall inserts a bubble, else capture the decoded ID slot
  always_comb begin
    idex_d = '0;
    if (!bus.flush && !stall && id_dec.valid) begin
      idex_d.dec      = id_dec;
      idex_d.rd       = bus.id_rd;
      idex_d.rs1      = bus.id_rs1;
      idex_d.rs2      = bus.id_rs2;
      idex_d.rs1_data = bus.id_rs1_data;
      idex_d.rs2_data = bus.id_rs2_data;
      idex_d.imm      = bus.id_imm;
      idex_d.pc       = bus.id_pc;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  // Forwarded source values and ALU operand muxes
  always_comb begin
    rs1_val = fwd_operand(idex_q.dec.use_rs1, idex_q.rs1, idex_q.rs1_data,
                          bus.mem_regwrite, bus.mem_rd, bus.mem_result,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_result);
    rs2_val = fwd_operand(idex_q.dec.use_rs2, idex_q.rs2, idex_q.rs2_data,
                          bus.mem_regwrite, bus.mem_rd, bus.mem_result,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_result);
    case (idex_q.dec.src1_sel)
      SRC1_RS1: src1 = rs1_val;
      SRC1_PC:  src1 = idex_q.pc;
      default:  src1 = '0;
    endcase
    src2 = (idex_q.dec.src2_sel == SRC2_RS2) ? rs2_val : idex_q.imm;
  end

  assign bus.id_stall      = stall;
  assign bus.alusrc1       = src1;
  assign bus.alusrc2       = src2;
  assign bus.alu_control   = idex_q.dec.alu;
  assign bus.ex_valid      = idex_q.dec.valid;
  assign bus.ex_regwrite   = idex_q.dec.regwrite;
  assign bus.ex_memread    = idex_q.dec.memread;
  assign bus.ex_memwrite   = idex_q.dec.memwrite;
  assign bus.ex_rd         = idex_q.rd;
  assign bus.ex_store_data = rs2_val;
  assign bus.ex_pc         = idex_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with a queue-based scoreboard.
module tb_alu_issue_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic        valid, rw, mr, mw;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic [31:0] a1, a2, sd, pc;
    logic        chk_sd;
    logic        stall;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL c%0d %s: got %h expected %h", id, nm, got, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("ex_valid",    mon_e.id, 32'(bus.ex_valid),    32'(mon_e.valid));
      chk("ex_regwrite", mon_e.id, 32'(bus.ex_regwrite), 32'(mon_e.rw));
      chk("ex_memread",  mon_e.id, 32'(bus.ex_memread),  32'(mon_e.mr));
      chk("ex_memwrite", mon_e.id, 32'(bus.ex_memwrite), 32'(mon_e.mw));
      chk("ex_rd",       mon_e.id, 32'(bus.ex_rd),       32'(mon_e.rd));
      chk("alu_control", mon_e.id, 32'(bus.alu_control), 32'(mon_e.alu));
      chk("alusrc1",     mon_e.id, bus.alusrc1,          mon_e.a1);
      chk("alusrc2",     mon_e.id, bus.alusrc2,          mon_e.a2);
      chk("ex_pc",       mon_e.id, bus.ex_pc,            mon_e.pc);
      chk("id_stall",    mon_e.id, 32'(bus.id_stall),    32'(mon_e.stall));
      if (mon_e.chk_sd) chk("ex_store_data", mon_e.id, bus.ex_store_data, mon_e.sd);
    end
  end

  task automatic set_id(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm);
    bus.id_valid = v;   bus.id_opcode = opc; bus.id_funct3 = f3; bus.id_funct7_5 = f7;
    bus.id_pc = pc;     bus.id_rs1 = rs1;    bus.id_rs2 = rs2;   bus.id_rd = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
    bus.flush = 1'b0;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    bus.mem_regwrite = mw; bus.mem_rd = mrd; bus.mem_result = mres;
    bus.wb_regwrite  = ww; bus.wb_rd  = wrd; bus.wb_result  = wres;
  endtask

  task automatic expect_o(input logic v, input logic rw, input logic mr, input logic mw,
                          input logic [4:0] rd, input logic [2:0] alu, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] sd, input logic csd,
                          input logic [31:0] pc, input logic st);
    exp_t e;
    e.id = cyc; e.valid = v; e.rw = rw; e.mr = mr; e.mw = mw; e.rd = rd; e.alu = alu;
    e.a1 = a1; e.a2 = a2; e.sd = sd; e.chk_sd = csd; e.pc = pc; e.stall = st;
    sb.push_back(e);
  endtask

  task automatic expect_bubble(input logic csd, input logic st);
    expect_o(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0, csd, 32'h0, st);
  endtask

  task automatic tick();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 7'h0, 3'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // C0: reset state; present sub x8,x6,x7 (5-3)
    set_id(1, OP_RTYPE, 3'b000, 1, 32'h100, 6, 7, 8, 32'd5, 32'd3, 32'h0);
    expect_bubble(1, 0); tick();
    // C1: sub in EX; present addi x1,x0,7 (bit30 set must not turn it into sub)
    set_id(1, OP_IALU, 3'b000, 1, 32'h104, 0, 7, 1, 32'h0, 32'h55, 32'd7);
    expect_o(1, 1, 0, 0, 8, ALU_SUB, 32'd5, 32'd3, 32'd3, 1, 32'h100, 0); tick();
    // C2: addi in EX, x0 never forwarded; present xor x2,x1,x1
    set_id(1, OP_RTYPE, 3'b100, 0, 32'h108, 1, 1, 2, 32'h99, 32'h99, 32'h0);
    set_fwd(1, 0, 32'hDEAD, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 1, ALU_ADD, 32'h0, 32'd7, 32'h55, 1, 32'h104, 0); tick();
    // C3: xor x2 gets 7 from EX/MEM; present xor x3,x1,x1
    set_id(1, OP_RTYPE, 3'b100, 0, 32'h10C, 1, 1, 3, 32'h99, 32'h99, 32'h0);
    set_fwd(1, 1, 32'd7, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 2, ALU_XOR, 32'd7, 32'd7, 32'd7, 1, 32'h108, 0); tick();
    // C4: mem_rd=0 -> no forwarding; present add x10,x9,x0
    set_id(1, OP_RTYPE, 3'b000, 0, 32'h110, 9, 0, 10, 32'h77, 32'h0, 32'h0);
    set_fwd(1, 0, 32'd7, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 3, ALU_XOR, 32'h99, 32'h99, 32'h99, 1, 32'h10C, 0); tick();
    // C5: EX/MEM beats MEM/WB on x9; present lw x4,8(x11)
    set_id(1, OP_LOAD, 3'b010, 0, 32'h114, 11, 8, 4, 32'h1000, 32'h33, 32'd8);
    set_fwd(1, 9, 32'hA, 1, 9, 32'hB);
    expect_o(1, 1, 0, 0, 10, ALU_ADD, 32'hA, 32'h0, 32'h0, 1, 32'h110, 0); tick();
    // C6: lw in EX; add x5,x4,x0 in ID -> stall
    set_id(1, OP_RTYPE, 3'b000, 0, 32'h118, 4, 0, 5, 32'h44, 32'h0, 32'h0);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    expect_o(1, 1, 1, 0, 4, ALU_ADD, 32'h1000, 32'd8, 32'h33, 1, 32'h114, 1); tick();
    // C7: bubble in EX, add re-presented
    set_id(1, OP_RTYPE, 3'b000, 0, 32'h118, 4, 0, 5, 32'h44, 32'h0, 32'h0);
    expect_bubble(0, 0); tick();
    // C8: add gets x4 from MEM/WB; present lw x7,0(x2)
    set_id(1, OP_LOAD, 3'b010, 0, 32'h11C, 2, 0, 7, 32'h2000, 32'h0, 32'h0);
    set_fwd(0, 0, 32'h0, 1, 4, 32'hCAFE);
    expect_o(1, 1, 0, 0, 5, ALU_ADD, 32'hCAFE, 32'h0, 32'h0, 1, 32'h118, 0); tick();
    // C9: load-use with flush -> no stall, bubble
    set_id(1, OP_RTYPE, 3'b000, 0, 32'h120, 7, 7, 8, 32'h0, 32'h0, 32'h0);
    bus.flush = 1'b1;
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    expect_o(1, 1, 1, 0, 7, ALU_ADD, 32'h2000, 32'h0, 32'h0, 1, 32'h11C, 0); tick();
    // C10: flushed bubble; present lui x9 with rs1 field 5
    set_id(1, OP_LUI, 3'b000, 0, 32'h124, 5, 0, 9, 32'h777, 32'h0, 32'h12345000);
    expect_bubble(0, 0); tick();
    // C11: lui ignores a matching EX/MEM rd; present auipc x10
    set_id(1, OP_AUIPC, 3'b000, 0, 32'h128, 0, 0, 10, 32'h0, 32'h0, 32'h1000);
    set_fwd(1, 5, 32'hBAD, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 9, ALU_ADD, 32'h0, 32'h12345000, 32'h0, 1, 32'h124, 0); tick();
    // C12: auipc uses pc; present sw x3,4(x2)
    set_id(1, OP_STORE, 3'b010, 0, 32'h12C, 2, 3, 4, 32'h3000, 32'h11, 32'd4);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 10, ALU_ADD, 32'h128, 32'h1000, 32'h0, 1, 32'h128, 0); tick();
    // C13: store data forwarded; present beq x1,x2
    set_id(1, OP_BRANCH, 3'b000, 0, 32'h130, 1, 2, 0, 32'd10, 32'd20, 32'h10);
    set_fwd(1, 3, 32'h5A5A, 0, 0, 32'h0);
    expect_o(1, 0, 0, 1, 4, ALU_ADD, 32'h3000, 32'd4, 32'h5A5A, 1, 32'h12C, 0); tick();
    // C14: branch subtracts, no write; present andi x11,x1,0xF
    set_id(1, OP_IALU, 3'b111, 0, 32'h134, 1, 15, 11, 32'hFF, 32'h0, 32'hF);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    expect_o(1, 0, 0, 0, 0, ALU_SUB, 32'd10, 32'd20, 32'd20, 1, 32'h130, 0); tick();
    // C15: andi; unused rs2 field not forwarded; present or x12
    set_id(1, OP_RTYPE, 3'b110, 0, 32'h138, 1, 2, 12, 32'd1, 32'd2, 32'h0);
    set_fwd(1, 15, 32'hEE, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 11, ALU_AND, 32'hFF, 32'hF, 32'h0, 1, 32'h134, 0); tick();
    // C16: or; present funct3=001 R-type
    set_id(1, OP_RTYPE, 3'b001, 0, 32'h13C, 1, 2, 13, 32'd3, 32'd4, 32'h0);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    expect_o(1, 1, 0, 0, 12, ALU_OR, 32'd1, 32'd2, 32'd2, 1, 32'h138, 0); tick();
    // C17: unsupported funct3 -> NOP code, still writes; present unknown opcode
    set_id(1, 7'b1111111, 3'b000, 0, 32'h140, 1, 2, 14, 32'd5, 32'd6, 32'h0);
    expect_o(1, 1, 0, 0, 13, ALU_NOP, 32'd3, 32'd4, 32'd4, 1, 32'h13C, 0); tick();
    // C18: unknown opcode became bubble; present lw x14
    set_id(1, OP_LOAD, 3'b010, 0, 32'h144, 1, 0, 14, 32'h50, 32'h0, 32'h0);
    expect_bubble(0, 0); tick();
    // C19: load-use stall with reset asserted
    set_id(1, OP_RTYPE, 3'b000, 0, 32'h148, 14, 0, 15, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    expect_o(1, 1, 1, 0, 14, ALU_ADD, 32'h50, 32'h0, 32'h0, 1, 32'h144, 1); tick();
    // C20: reset cleared everything, stall drops
    rst = 1'b0;
    set_id(1, OP_RTYPE, 3'b000, 0, 32'h148, 14, 0, 15, 32'h0, 32'h0, 32'h0);
    expect_bubble(1, 0); tick();
    // C21: held add now issues normally
    set_id(0, 7'h0, 3'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    expect_o(1, 1, 0, 0, 15, ALU_ADD, 32'h0, 32'h0, 32'h0, 1, 32'h148, 0); tick();
    // C22: idle
    expect_bubble(0, 0); tick();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
